// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V controller:
// FSM state encoding, opcode values and datapath mux-select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRLINK = 4'd12
  } state_t;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IALU   = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// Opcode lookup: immediate format and the state that follows DECODE.
// Unsupported opcodes return to FETCH and are flagged illegal.
module instr_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src,
  output state_t     dec_next,
  output logic       dec_illegal
);

  // opcode -> immediate format, post-DECODE state, illegal flag
  always_comb begin
    imm_src     = IMM_I;
    dec_next    = S_FETCH;
    dec_illegal = 1'b0;
    case (opcode)
      OP_LOAD:   dec_next = S_MEMADR;
      OP_STORE:  begin
        imm_src  = IMM_S;
        dec_next = S_MEMADR;
      end
      OP_R:      dec_next = S_EXECR;
      OP_IALU:   dec_next = S_EXECI;
      OP_BRANCH: begin
        imm_src  = IMM_B;
        dec_next = S_BEQ;
      end
      OP_JAL:    begin
        imm_src  = IMM_J;
        dec_next = S_JAL;
      end
      OP_JALR:   dec_next = S_JALR;
      default:   dec_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V controller: state register plus per-state decode of the
// datapath enables and mux selects. Enables are gated by rst and mem_ready.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic               retire,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state_r;
  state_t dec_next_s;
  logic   dec_illegal_s;
  logic   pc_update_s;
  logic   branch_s;

  instr_dec u_dec (
    .opcode      (opcode),
    .imm_src     (ImmSrc),
    .dec_next    (dec_next_s),
    .dec_illegal (dec_illegal_s)
  );

  // state register and next-state sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      case (state_r)
        S_FETCH:    state_r <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE:   state_r <= dec_next_s;
        S_MEMADR: begin
          if (opcode == OP_LOAD)       state_r <= S_MEMREAD;
          else if (opcode == OP_STORE) state_r <= S_MEMWRITE;
          else                         state_r <= S_FETCH;
        end
        S_MEMREAD:  state_r <= mem_ready ? S_MEMWB : S_MEMREAD;
        S_MEMWB:    state_r <= S_FETCH;
        S_MEMWRITE: state_r <= mem_ready ? S_FETCH : S_MEMWRITE;
        S_EXECR:    state_r <= S_ALUWB;
        S_EXECI:    state_r <= S_ALUWB;
        S_ALUWB:    state_r <= S_FETCH;
        S_BEQ:      state_r <= S_FETCH;
        S_JAL:      state_r <= S_ALUWB;
        S_JALR:     state_r <= S_JALRLINK;
        S_JALRLINK: state_r <= S_ALUWB;
        default:    state_r <= S_FETCH;
      endcase
    end
  end

  // per-state control decode; rst shows FETCH selects with every enable low
  always_comb begin
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RD2;
    ALUOp       = ALUOP_ADD;
    RegWrite    = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    if (rst) begin
      ALUSrcB   = SRCB_FOUR;
      ResultSrc = RES_ALURESULT;
    end else begin
      case (state_r)
        S_FETCH: begin
          ALUSrcB     = SRCB_FOUR;
          ResultSrc   = RES_ALURESULT;
          IRWrite     = mem_ready;
          pc_update_s = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          illegal = dec_illegal_s;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMREAD:  AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
          retire    = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          retire   = mem_ready;
        end
        S_EXECR: begin
          ALUSrcA = SRCA_RD1;
          ALUOp   = ALUOP_FUNCT;
        end
        S_EXECI: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA  = SRCA_RD1;
          ALUOp    = ALUOP_SUB;
          branch_s = 1'b1;
          retire   = 1'b1;
        end
        S_JAL: begin
          ALUSrcA     = SRCA_OLDPC;
          ALUSrcB     = SRCB_FOUR;
          pc_update_s = 1'b1;
        end
        S_JALR: begin
          ALUSrcA     = SRCA_RD1;
          ALUSrcB     = SRCB_IMM;
          ResultSrc   = RES_ALURESULT;
          pc_update_s = 1'b1;
        end
        S_JALRLINK: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
        end
        default: begin
          AdrSrc = 1'b0;
        end
      endcase
    end
  end

  assign PCWrite   = pc_update_s | (branch_s & Zero);
  assign state_dbg = STATE_W'(state_r);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction expectations come
// from opcode latency/effect tables plus a few directed sequences.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] state_dbg;

  int checks = 0;
  int passes = 0;

  logic [3:0] st_log [64];
  logic       pcw_log[64];
  logic       rw_log [64];
  logic       ill_log[64];
  logic [1:0] res_log[64];
  logic [1:0] aop_log[64];

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .retire(retire), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic int latency(input logic [6:0] op);
    case (op)
      7'd51, 7'd19, 7'd35, 7'd111: return 4;
      7'd3, 7'd103:                return 5;
      7'd99:                       return 3;
      default:                     return 2;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      7'd35:   return 2'b01;
      7'd99:   return 2'b10;
      7'd111:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Runs one instruction: fw fetch wait cycles, mw memory wait cycles,
  // zmode 0/1 forces Zero, 2 randomizes it every cycle.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input int zmode);
    bit memop, legal, writes_rd;
    int len, irw_cnt, irw_pos, ret_cnt, ret_pos, ill_pos, rw_cnt, mwr_cnt, pcw_cnt;
    logic z_beq;
    logic [1:0] imm_seen;
    memop = (op == 7'd3) || (op == 7'd35);
    legal = (latency(op) != 2);
    writes_rd = (op == 7'd51) || (op == 7'd19) || (op == 7'd3) || (op == 7'd111) || (op == 7'd103);
    len = latency(op) + fw + (memop ? mw : 0);
    irw_cnt = 0; irw_pos = -1; ret_cnt = 0; ret_pos = -1; ill_pos = -1;
    rw_cnt = 0; mwr_cnt = 0; pcw_cnt = 0; z_beq = 1'b0; imm_seen = 2'b00;
    for (int c = 0; c < len; c++) begin
      opcode = op;
      if (c < fw) mem_ready = 1'b0;
      else if (c == fw) mem_ready = 1'b1;
      else if (memop && c >= fw + 3 && c < fw + 3 + mw) mem_ready = 1'b0;
      else if (memop && c == fw + 3 + mw) mem_ready = 1'b1;
      else mem_ready = 1'($urandom % 2);
      Zero = (zmode == 2) ? 1'($urandom % 2) : (zmode == 1);
      if (c == fw + 2) z_beq = Zero;
      @(negedge clk);
      st_log[c] = state_dbg; pcw_log[c] = PCWrite; rw_log[c] = RegWrite;
      ill_log[c] = illegal; res_log[c] = ResultSrc; aop_log[c] = ALUOp;
      if (IRWrite) begin irw_cnt++; irw_pos = c; end
      if (retire) begin ret_cnt++; ret_pos = c; end
      if (illegal) ill_pos = c;
      if (RegWrite) rw_cnt++;
      if (MemWrite) mwr_cnt++;
      if (PCWrite) pcw_cnt++;
      if (c == 0) imm_seen = ImmSrc;
      @(posedge clk); #1;
    end
    chk("irwrite_cnt", irw_cnt, 1);
    chk("irwrite_pos", irw_pos, fw);
    chk("retire_cnt", ret_cnt, legal ? 1 : 0);
    chk("retire_pos", ret_pos, legal ? len - 1 : -1);
    chk("illegal_pos", ill_pos, legal ? -1 : fw + 1);
    chk("regwrite_cnt", rw_cnt, writes_rd ? 1 : 0);
    chk("memwrite_cnt", mwr_cnt, (op == 7'd35) ? mw + 1 : 0);
    chk("pcwrite_cnt", pcw_cnt,
        1 + (((op == 7'd111) || (op == 7'd103)) ? 1 : 0) + (((op == 7'd99) && z_beq) ? 1 : 0));
    chk("immsrc", imm_seen, imm_of(op));
  endtask

  initial begin
    logic [6:0] ops[8];
    logic [6:0] op;
    ops[0] = 7'd51; ops[1] = 7'd3; ops[2] = 7'd19; ops[3] = 7'd35;
    ops[4] = 7'd99; ops[5] = 7'd111; ops[6] = 7'd103; ops[7] = 7'h37;

    // reset: enables low, FETCH selects visible
    rst = 1'b1; opcode = 7'd51; mem_ready = 1'b1; Zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_enables", {PCWrite, IRWrite, RegWrite, MemWrite, retire, illegal}, 6'b0);
      chk("rst_resultsrc", ResultSrc, 2'b10);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // R-type right after reset
    run_instr(7'd51, 0, 0, 2);
    chk("r_st0", st_log[0], S_FETCH);
    chk("r_pcw0", pcw_log[0], 1'b1);
    chk("r_st1", st_log[1], S_DECODE);
    chk("r_st2", st_log[2], S_EXECR);
    chk("r_aluop2", aop_log[2], 2'b10);
    chk("r_st3", st_log[3], S_ALUWB);
    chk("r_rw3", rw_log[3], 1'b1);

    // load with three memory wait cycles
    run_instr(7'd3, 0, 3, 2);
    for (int c = 3; c < 7; c++) begin
      chk("ld_memread", st_log[c], S_MEMREAD);
      chk("ld_rw_wait", rw_log[c], 1'b0);
    end
    chk("ld_st7", st_log[7], S_MEMWB);
    chk("ld_res7", res_log[7], 2'b01);

    // branch taken / not taken
    run_instr(7'd99, 0, 0, 1);
    chk("beq_taken", pcw_log[2], 1'b1);
    run_instr(7'd99, 0, 0, 0);
    chk("beq_not_taken", pcw_log[2], 1'b0);

    // JALR path
    run_instr(7'd103, 0, 0, 2);
    chk("jalr_st2", st_log[2], S_JALR);
    chk("jalr_pcw2", pcw_log[2], 1'b1);
    chk("jalr_res2", res_log[2], 2'b10);
    chk("jalr_st3", st_log[3], S_JALRLINK);
    chk("jalr_st4", st_log[4], S_ALUWB);
    chk("jalr_rw4", rw_log[4], 1'b1);

    // illegal opcode
    run_instr(7'h37, 0, 0, 2);
    chk("ill_st1", st_log[1], S_DECODE);
    chk("ill_flag1", ill_log[1], 1'b1);

    // randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(7)];
      if (op == 7'h37) op = 7'($urandom);
      run_instr(op, $urandom_range(2), $urandom_range(3), 2);
    end

    // reset during a store wait aborts it
    opcode = 7'd35; Zero = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c == 0);
      @(negedge clk);
      if (c >= 3) begin
        chk("st_wait_state", state_dbg, S_MEMWRITE);
        chk("st_wait_memwrite", MemWrite, 1'b1);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    chk("st_rst_memwrite", MemWrite, 1'b0);
    chk("st_rst_retire", retire, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("st_rst_fetch", state_dbg, S_FETCH);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
